// File: rtl/lfsr_bus_pkg.sv
// Shared types and constants for the LFSR read controller: FSM states, default polynomial/seed, counter width.
// Pure declarations; no latency or flow control of its own.
package lfsr_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRIVE   = 2'd2,
        HOLD    = 2'd3
    } rd_state_e;

    localparam logic [31:0] DEF_POLY = 32'h8020_0003;
    localparam logic [31:0] DEF_SEED = 32'h0000_0001;
    localparam int          CNT_W    = 4;

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR register: one step per cycle with step=1, load has priority over step.
// Single-cycle update; no backpressure, the caller decides when to step.
module lfsr32_galois #(
    parameter logic [31:0] POLY = 32'h8020_0003,
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] q
);

    logic [31:0] q_q;
    logic [31:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (step) begin
            q_d = q_q[0] ? ((q_q >> 1) ^ POLY) : (q_q >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/lfsr_rd_ctrl.sv
// Bus read controller feeding a fresh LFSR word: q1_id one cycle after accept, D_en for DRIVE_CYCLES, rdy on the last drive cycle.
// The master holds rd until rdy; HOLD waits for rd to drop. Optional seed load ports under LFSR_SEED_LOAD_EN.
module lfsr_rd_ctrl
    import lfsr_bus_pkg::*;
#(
    parameter logic [31:0] POLY         = DEF_POLY,
    parameter logic [31:0] SEED         = DEF_SEED,
    parameter int          DRIVE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic        A_eq_Faddr,
`ifdef LFSR_SEED_LOAD_EN
    input  logic        seed_ld,
    input  logic [31:0] seed,
`endif
    output logic [31:0] Q,
    output logic        q1_id,
    output logic        D_en,
    output logic        rdy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRIVE_CYCLES - 1);

    rd_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q1_id_q, d_en_q, rdy_q;
    logic             lfsr_step, lfsr_ld;
    logic [31:0]      lfsr_ld_val;

`ifdef LFSR_SEED_LOAD_EN
    assign lfsr_ld_val = (seed == 32'd0) ? SEED : seed;
`else
    assign lfsr_ld_val = SEED;
`endif

    // The word is captured at the edge leaving CAPTURE, so the step happens there too.
    assign lfsr_step = (state_q == CAPTURE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_ld = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef LFSR_SEED_LOAD_EN
                if (seed_ld) begin
                    lfsr_ld = 1'b1;
                end else if (rd && A_eq_Faddr) begin
                    state_d = CAPTURE;
                end
`else
                if (rd && A_eq_Faddr) begin
                    state_d = CAPTURE;
                end
`endif
            end
            CAPTURE: begin
                state_d = DRIVE;
                cnt_d   = CNT_LOAD;
            end
            DRIVE: begin
                if (!rd) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (!rd) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q1_id_q <= 1'b0;
            d_en_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q1_id_q <= (state_d == CAPTURE);
            d_en_q  <= (state_d == DRIVE);
            rdy_q   <= (state_d == DRIVE) && (cnt_d == '0);
        end
    end

    lfsr32_galois #(
        .POLY (POLY),
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .step     (lfsr_step),
        .load     (lfsr_ld),
        .load_val (lfsr_ld_val),
        .q        (Q)
    );

    assign q1_id = q1_id_q;
    assign D_en  = d_en_q;
    assign rdy   = rdy_q;

endmodule

// File: tb/tb_lfsr_rd_ctrl.sv
// Directed bench for lfsr_rd_ctrl with default parameters (DRIVE_CYCLES=2).
// Seed-load steps are compiled in when LFSR_SEED_LOAD_EN is defined.
module tb_lfsr_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd;
    logic        A_eq_Faddr;
    logic [31:0] Q;
    logic        q1_id;
    logic        D_en;
    logic        rdy;
`ifdef LFSR_SEED_LOAD_EN
    logic        seed_ld;
    logic [31:0] seed;
`endif

    int checks = 0;
    int errors = 0;
    int n_q1, n_den, n_rdy;

    always #5 clk = ~clk;

    lfsr_rd_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rd         (rd),
        .A_eq_Faddr (A_eq_Faddr),
`ifdef LFSR_SEED_LOAD_EN
        .seed_ld    (seed_ld),
        .seed       (seed),
`endif
        .Q          (Q),
        .q1_id      (q1_id),
        .D_en       (D_en),
        .rdy        (rdy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic q1, input logic de, input logic ry);
        check({tag, ".q1_id"}, {31'd0, q1_id}, {31'd0, q1});
        check({tag, ".D_en"},  {31'd0, D_en},  {31'd0, de});
        check({tag, ".rdy"},   {31'd0, rdy},   {31'd0, ry});
    endtask

    initial begin
        rst = 1'b0; rd = 1'b0; A_eq_Faddr = 1'b0;
`ifdef LFSR_SEED_LOAD_EN
        seed_ld = 1'b0; seed = 32'd0;
`endif
        tick(); tick();
        check("reset.Q", Q, 32'h0000_0001);
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        // Matched read, cycle 0 = accept cycle
        rd = 1'b1; A_eq_Faddr = 1'b1;
        tick();
        check_outs("rd1.c1", 1'b1, 1'b0, 1'b0);
        check("rd1.c1.Q", Q, 32'h0000_0001);
        A_eq_Faddr = 1'b0;
        tick();
        check_outs("rd1.c2", 1'b0, 1'b1, 1'b0);
        check("rd1.c2.Q", Q, 32'h8020_0003);
        tick();
        check_outs("rd1.c3", 1'b0, 1'b1, 1'b1);
        tick();
        check_outs("rd1.hold", 1'b0, 1'b0, 1'b0);
        rd = 1'b0;
        tick();

        rd = 1'b1; A_eq_Faddr = 1'b1;
        tick(); tick();
        check("rd2.Q", Q, 32'hC030_0002);
        tick(); tick();
        rd = 1'b0;
        tick();

        // Unmatched read for 10 cycles
        rd = 1'b1; A_eq_Faddr = 1'b0;
        n_q1 = 0; n_den = 0; n_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_q1 += int'(q1_id); n_den += int'(D_en); n_rdy += int'(rdy);
        end
        check("unmatched.pulses", 32'(n_q1 + n_den + n_rdy), 32'd0);
        check("unmatched.Q", Q, 32'hC030_0002);

        // Held strobe for 20 cycles
        A_eq_Faddr = 1'b1;
        n_q1 = 0; n_den = 0; n_rdy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_q1 += int'(q1_id); n_den += int'(D_en); n_rdy += int'(rdy);
        end
        check("held.q1_id", 32'(n_q1), 32'd1);
        check("held.rdy", 32'(n_rdy), 32'd1);
        check("held.D_en", 32'(n_den), 32'd2);
        check("held.Q", Q, 32'h6018_0001);
        rd = 1'b0;
        tick();

        // Abort in first DRIVE cycle
        rd = 1'b1;
        tick(); tick();
        check_outs("abort.drive", 1'b0, 1'b1, 1'b0);
        rd = 1'b0;
        tick();
        check_outs("abort.after", 1'b0, 1'b0, 1'b0);
        check("abort.Q", Q, 32'hB02C_0003);
        tick();
        check_outs("abort.idle", 1'b0, 1'b0, 1'b0);
        rd = 1'b1;
        tick();
        check_outs("abort.reaccept", 1'b1, 1'b0, 1'b0);
        tick();
        check_outs("midrst.drive", 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        check_outs("midrst", 1'b0, 1'b0, 1'b0);
        check("midrst.Q", Q, 32'h0000_0001);
        rst = 1'b1; rd = 1'b0;
        tick();
        check_outs("midrst.idle", 1'b0, 1'b0, 1'b0);

`ifdef LFSR_SEED_LOAD_EN
        seed_ld = 1'b1; seed = 32'hDEAD_BEEF;
        tick();
        check("seed.load", Q, 32'hDEAD_BEEF);
        seed = 32'd0;
        tick();
        check("seed.zero", Q, 32'h0000_0001);
        seed = 32'h1234_5678; rd = 1'b1; A_eq_Faddr = 1'b1;
        tick();
        check("seed.win.Q", Q, 32'h1234_5678);
        check_outs("seed.win", 1'b0, 1'b0, 1'b0);
        seed_ld = 1'b0;
        tick();
        check_outs("seed.nextacc", 1'b1, 1'b0, 1'b0);
        tick();
        check("seed.step", Q, 32'h091A_2B3C);
        seed_ld = 1'b1; seed = 32'hDEAD_BEEF;
        tick();
        check("seed.ignored", Q, 32'h091A_2B3C);
        seed_ld = 1'b0; rd = 1'b0;
        tick(); tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_rd_ctrl.md
# lfsr_rd_ctrl

- Upstream stage of the bus-interface data register: a 32-bit Galois LFSR generator plus a read-control state machine.
- Decodes a bus read aimed at this slave and pulses `q1_id` so the data register captures `Q`.
- Asserts `D_en` for a fixed number of cycles so the register drives the tri-state bus, and returns `rdy` to the bus master.
- Advances the LFSR once per accepted read, so every read returns a fresh pseudo-random word.

## Interface
Parameters:
- `POLY`, 32'h8020_0003, Galois feedback mask (x^32+x^22+x^2+x+1).
- `SEED`, 32'h0000_0001, LFSR reset value; must be nonzero.
- `DRIVE_CYCLES`, 2, cycles `D_en` is held high; legal range 1..15.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: reset, synchronous, active-low.
- `rd` in 1: bus read strobe, level, held by master until `rdy`.
- `A_eq_Faddr` in 1: address-match from data stage.
- `Q` out 32: current LFSR state; feeds data register input.
- `q1_id` out 1: one-cycle capture pulse to data register.
- `D_en` out 1: tri-state drive enable to data register.
- `rdy` out 1: one-cycle read-complete pulse to master.
- `seed_ld` in 1 and `seed` in 32: present only with `LFSR_SEED_LOAD_EN`.

## Operation
- **Reset** (`rst`=0 at posedge): `Q`=SEED, state IDLE, `q1_id`=0, `D_en`=0, `rdy`=0, drive counter 0. Reset mid-transaction aborts it; `D_en` is low the cycle after.
- **LFSR step**: `Q` <= `Q[0]` ? (`Q`>>1)^POLY : `Q`>>1. The LFSR steps only on the posedge that leaves CAPTURE and is otherwise held. All-zero is unreachable from a nonzero seed.
- **IDLE**: `rd` && `A_eq_Faddr` -> CAPTURE. Otherwise stay.
- **CAPTURE** (1 cycle): `q1_id`=1. Always -> DRIVE, counter loaded with DRIVE_CYCLES-1.
- **DRIVE**:
  - `D_en`=1 while in this state.
  - Counter decrements each cycle. When counter=0, `rdy`=1 and -> HOLD.
  - `rd` low during DRIVE (abort) -> IDLE, no `rdy`.
- **HOLD**:
  - `D_en`=0, waits for `rd`=0, then -> IDLE.
  - Ensures one held strobe produces exactly one read.
- **Output registration**: `q1_id`, `D_en` and `rdy` are registered and decoded from the next state, so each is high exactly during its state.
- **`A_eq_Faddr` sampling**: sampled only in IDLE. Changes after acceptance are ignored.

## Timing
- **Read latency**:
  - Cycle N: `rd`&&`A_eq_Faddr` sampled.
  - N+1: `q1_id`=1; data register loads `Q` at end of N+1; `Q` steps at the same edge.
  - N+2 .. N+1+DRIVE_CYCLES: `D_en`=1.
  - `rdy`=1 in cycle N+1+DRIVE_CYCLES.
  - Cycle N+2+DRIVE_CYCLES: HOLD.
- **Back-to-back reads**: `rd` must drop for at least one cycle. Minimum read period is DRIVE_CYCLES+3 cycles.
- **Abort**: `rd`=0 sampled in DRIVE gives `D_en`=0 the next cycle. The LFSR has already stepped.

## Configuration
- **`LFSR_SEED_LOAD_EN` defined**: adds the `seed_ld` and `seed` ports.
  - In IDLE, `seed_ld`=1 loads `Q` <= `seed`, or SEED if `seed`==0.
  - `seed_ld` outside IDLE is ignored.
  - `seed_ld` and a read accepted in the same cycle: the load wins and the read is accepted next cycle if `rd` is still high.
- **Undefined**: ports absent; `Q` is changed only by reset and read steps.

## Structure
- Package `lfsr_bus_pkg` holds:
  - state enum (IDLE, CAPTURE, DRIVE, HOLD);
  - default POLY and SEED constants;
  - drive-counter width (4 bits).
- Sub-module `lfsr32_galois`: ports `clk`, `rst`, `step`, `load`, `load_val`, `q`. It holds the next-state function; the FSM lives in `lfsr_rd_ctrl`.

## Test plan
- **Reset**: assert `rst`=0 for 2 cycles -> `Q`=32'h0000_0001, `q1_id`=`D_en`=`rdy`=0.
- **Matched read**: `rd`=1, `A_eq_Faddr`=1 at cycle 0 -> `q1_id` high cycle 1 only; `D_en` high cycles 2-3; `rdy` cycle 3; `Q`=32'h8020_0003 from cycle 2. A second read gives `Q`=32'hC030_0002.
- **Unmatched read**: `rd`=1, `A_eq_Faddr`=0 for 10 cycles -> no `q1_id`, `D_en` or `rdy`; `Q` unchanged.
- **Held strobe**: `rd` held 20 cycles -> exactly one `q1_id` and one `rdy` pulse.
- **Abort**: drop `rd` in the first DRIVE cycle -> `D_en` low the next cycle, no `rdy`, state IDLE. Then reset mid-DRIVE -> all outputs 0, `Q`=SEED.
- **With `LFSR_SEED_LOAD_EN`**:
  - `seed_ld`=1 with `seed`=32'hDEAD_BEEF -> `Q`=32'hDEAD_BEEF next cycle.
  - `seed`=0 -> `Q`=32'h0000_0001.
